// File: rtl/dec2bin64_parser.sv
// Streaming ASCII-decimal to 64-bit binary parser with overflow and bad-character reporting.
// Optional signed input ('-' prefix, two's complement result) enabled by DEC2BIN_SIGNED_EN.
module dec2bin64_parser #(
   parameter int unsigned MAX_DIGITS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  char_in,
   input  logic        char_valid,
   output logic        char_ready,
   output logic [63:0] value_out,
   output logic        value_valid,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
`ifdef DEC2BIN_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, ACCUM, DISCARD, DONE} state_t;

   state_t          state_q, state_d;
   logic [63:0]     acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic            bad_q, bad_d;
   logic            neg_q, neg_d;
   logic            char_ready_q, char_ready_d;
   logic [63:0]     value_out_q, value_out_d;
   logic            value_valid_q, value_valid_d;
   logic            err_q, err_d;
   logic [1:0]      err_code_q, err_code_d;

   logic            take, is_digit, is_term, is_space, is_minus, too_big;
   logic [67:0]     prod;

   always_comb begin
      take     = char_valid && char_ready_q;
      is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
      is_term  = (char_in == 8'h0D) || (char_in == 8'h0A);
      is_space = (char_in == 8'h20);
      is_minus = (char_in == 8'h2D);
      prod     = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {64'b0, char_in[3:0]};
`ifdef DEC2BIN_SIGNED_EN
      too_big  = neg_q ? (prod > 68'h8000_0000_0000_0000) : (prod > 68'h7FFF_FFFF_FFFF_FFFF);
`else
      too_big  = |prod[67:64];
`endif

      state_d       = state_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      ovf_d         = ovf_q;
      bad_d         = bad_q;
      neg_d         = neg_q;
      value_out_d   = value_out_q;
      value_valid_d = 1'b0;
      err_d         = 1'b0;
      err_code_d    = err_code_q;

      case (state_q)
         IDLE: begin
            if (take) begin
               if (is_digit) begin
                  acc_d   = {60'b0, char_in[3:0]};
                  cnt_d   = CW'(1);
                  state_d = ACCUM;
               end else if (neg_q) begin
                  // a sign must be followed directly by a digit
                  bad_d   = 1'b1;
                  state_d = is_term ? DONE : DISCARD;
               end else if (is_term || is_space) begin
                  state_d = IDLE;
               end else if (SIGNED_EN && is_minus) begin
                  neg_d = 1'b1;
               end else begin
                  bad_d   = 1'b1;
                  state_d = DISCARD;
               end
            end
         end
         ACCUM: begin
            if (take) begin
               if (is_digit) begin
                  acc_d = prod[63:0];
                  if (cnt_q < CW'(MAX_DIGITS)) cnt_d = cnt_q + 1'b1;
                  if (too_big || (cnt_q >= CW'(MAX_DIGITS))) ovf_d = 1'b1;
               end else if (is_term) begin
                  state_d = DONE;
               end else begin
                  bad_d   = 1'b1;
                  state_d = DISCARD;
               end
            end
         end
         DISCARD: begin
            if (take && is_term) state_d = DONE;
         end
         DONE: begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            bad_d   = 1'b0;
            neg_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Result is registered on entry so the pulse coincides with the DONE cycle
      if (state_d == DONE && state_q != DONE) begin
         if (bad_d) begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
         end else if (ovf_d) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
         end else begin
            value_out_d   = neg_d ? (~acc_d + 64'd1) : acc_d;
            value_valid_d = 1'b1;
         end
      end

      char_ready_d = (state_d != DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         acc_q         <= '0;
         cnt_q         <= '0;
         ovf_q         <= 1'b0;
         bad_q         <= 1'b0;
         neg_q         <= 1'b0;
         char_ready_q  <= 1'b1;
         value_out_q   <= '0;
         value_valid_q <= 1'b0;
         err_q         <= 1'b0;
         err_code_q    <= 2'b00;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         ovf_q         <= ovf_d;
         bad_q         <= bad_d;
         neg_q         <= neg_d;
         char_ready_q  <= char_ready_d;
         value_out_q   <= value_out_d;
         value_valid_q <= value_valid_d;
         err_q         <= err_d;
         err_code_q    <= err_code_d;
      end
   end

   assign char_ready  = char_ready_q;
   assign value_out   = value_out_q;
   assign value_valid = value_valid_q;
   assign err         = err_q;
   assign err_code    = err_code_q;

endmodule

// File: tb/tb_dec2bin64_parser.sv
// Self-checking bench for dec2bin64_parser: directed table, multi-cycle corner cases,
// and randomized numbers checked against a string-level reference model.
module tb_dec2bin64_parser;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  char_in;
   logic        char_valid;
   logic        char_ready;
   logic [63:0] value_out;
   logic        value_valid;
   logic        err;
   logic [1:0]  err_code;

   int          nchk = 0;
   int          nerr = 0;
   int          both_cnt = 0;
   logic [63:0] last_good = '0;
   logic [63:0] vq[$];
   logic [1:0]  eq[$];

   typedef struct {
      string       s;
      int          kind;   // 0 none, 1 value, 2 error
      logic [63:0] v;
      logic [1:0]  code;
   } vec_t;
   vec_t vecs[$];

   dec2bin64_parser #(.MAX_DIGITS(20)) dut (
      .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
      .char_ready(char_ready), .value_out(value_out), .value_valid(value_valid),
      .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (value_valid) vq.push_back(value_out);
         if (err) eq.push_back(err_code);
         if (value_valid && err) both_cnt++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: leading spaces, optional '-' (signed build), then one or more digits only.
   function automatic void model(input string s, output int kind, output logic [63:0] v,
                                 output logic [1:0] code);
      int unsigned i = 0;
      int unsigned n = 0;
      bit neg = 0;
      bit bad;
      logic [127:0] mag = '0;
      logic [127:0] limit;
      while (i < s.len() && s[i] == " ") i++;
      kind = 0; v = '0; code = 2'b00;
      if (i == s.len()) return;
`ifdef DEC2BIN_SIGNED_EN
      if (s[i] == "-") begin neg = 1; i++; end
      limit = neg ? (128'd1 << 63) : ((128'd1 << 63) - 1);
`else
      limit = (128'd1 << 64) - 1;
`endif
      bad = (i == s.len());
      for (int unsigned j = i; j < s.len(); j++) begin
         if (s[j] >= "0" && s[j] <= "9") begin
            n++;
            if (mag < (128'd1 << 66)) mag = mag * 10 + 128'(s[j] - "0");
         end else bad = 1;
      end
      if (bad) begin kind = 2; code = 2'b10; end
      else if (n > 20 || mag > limit) begin kind = 2; code = 2'b01; end
      else begin
         kind = 1;
         v = neg ? (64'd0 - mag[63:0]) : mag[63:0];
      end
   endfunction

   task automatic send_char(input byte c, output int stalls);
      stalls = 0;
      @(negedge clk);
      char_valid = 1'b1;
      char_in    = c;
      while (!char_ready && stalls < 20) begin
         @(negedge clk);
         stalls++;
      end
      if (!char_ready) check("ready_timeout", {63'b0, char_ready}, 64'd1);
   endtask

   task automatic run_number(input string name, input string s, input int kind,
                             input logic [63:0] v, input logic [1:0] code, input bit gaps);
      int st;
      int nv0 = vq.size();
      int ne0 = eq.size();
      for (int i = 0; i < s.len(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            char_valid = 1'b0;
         end
         send_char(s[i], st);
      end
      @(negedge clk);
      char_valid = 1'b0;
      if (kind == 1) begin
         check({name, ".valid"}, {63'b0, value_valid}, 64'd1);
         check({name, ".value"}, value_out, v);
         check({name, ".ready"}, {63'b0, char_ready}, 64'd0);
      end else if (kind == 2) begin
         check({name, ".err"}, {63'b0, err}, 64'd1);
         check({name, ".code"}, {62'b0, err_code}, {62'b0, code});
         check({name, ".held"}, value_out, last_good);
         check({name, ".ready"}, {63'b0, char_ready}, 64'd0);
      end else begin
         check({name, ".quiet"}, {63'b0, value_valid | err}, 64'd0);
      end
      @(negedge clk);
      #1;
      check({name, ".nvalid"}, 64'(vq.size() - nv0), (kind == 1) ? 64'd1 : 64'd0);
      check({name, ".nerr"}, 64'(eq.size() - ne0), (kind == 2) ? 64'd1 : 64'd0);
      if (kind == 1) last_good = v;
   endtask

   initial begin
      string boundary[6];
      string body, term, bad_c;
      int kind, st, nv0, ne0;
      logic [63:0] v;
      logic [1:0] code;

      boundary[0] = "18446744073709551615";
      boundary[1] = "18446744073709551616";
      boundary[2] = "9223372036854775807";
      boundary[3] = "9223372036854775808";
      boundary[4] = "9223372036854775809";
      boundary[5] = "99999999999999999999";

      vecs.push_back('{"12345\015", 1, 64'd12345, 2'b00});
`ifndef DEC2BIN_SIGNED_EN
      vecs.push_back('{"18446744073709551615\012", 1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00});
      vecs.push_back('{"18446744073709551616\012", 2, 64'd0, 2'b01});
      vecs.push_back('{"-42\015", 2, 64'd0, 2'b10});
`else
      vecs.push_back('{"-42\015", 1, 64'hFFFF_FFFF_FFFF_FFD6, 2'b00});
      vecs.push_back('{"-9223372036854775808\015", 1, 64'h8000_0000_0000_0000, 2'b00});
      vecs.push_back('{"9223372036854775808\015", 2, 64'd0, 2'b01});
      vecs.push_back('{"9223372036854775807\015", 1, 64'h7FFF_FFFF_FFFF_FFFF, 2'b00});
      vecs.push_back('{"-9223372036854775809\015", 2, 64'd0, 2'b01});
      vecs.push_back('{"-\015", 2, 64'd0, 2'b10});
      vecs.push_back('{"--1\015", 2, 64'd0, 2'b10});
      vecs.push_back('{"- 1\012", 2, 64'd0, 2'b10});
`endif
      vecs.push_back('{"12a4\015", 2, 64'd0, 2'b10});
      vecs.push_back('{"6\015", 1, 64'd6, 2'b00});
      vecs.push_back('{"\015", 0, 64'd0, 2'b00});
      vecs.push_back('{"  5\012", 1, 64'd5, 2'b00});
      vecs.push_back('{"5 \015", 2, 64'd0, 2'b10});
      vecs.push_back('{"000000000000000000007\015", 2, 64'd0, 2'b01});
      vecs.push_back('{"00000000000000000007\015", 1, 64'd7, 2'b00});
      vecs.push_back('{"99999999999999999999999x\015", 2, 64'd0, 2'b10});
      vecs.push_back('{"/\015", 2, 64'd0, 2'b10});
      vecs.push_back('{":\012", 2, 64'd0, 2'b10});
      vecs.push_back('{"0\015", 1, 64'd0, 2'b00});

      rst = 1'b1; char_valid = 1'b0; char_in = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset.value_out", value_out, 64'd0);
      check("reset.flags", {60'b0, value_valid, err, err_code}, 64'd0);
      check("reset.ready", {63'b0, char_ready}, 64'd1);

      foreach (vecs[i])
         run_number($sformatf("vec%0d", i), vecs[i].s, vecs[i].kind, vecs[i].v, vecs[i].code, 1'b0);

      // held char_valid streaming "7\r\r8\r"
      nv0 = vq.size();
      send_char("7", st);  check("t4.stall7", 64'(st), 64'd0);
      send_char("\015", st); check("t4.stall_cr1", 64'(st), 64'd0);
      send_char("\015", st); check("t4.stall_cr2", 64'(st), 64'd1);
      send_char("8", st);  check("t4.stall8", 64'(st), 64'd0);
      send_char("\015", st);
      @(negedge clk);
      char_valid = 1'b0;
      check("t4.ready_low", {63'b0, char_ready}, 64'd0);
      @(negedge clk);
      #1;
      check("t4.npulses", 64'(vq.size() - nv0), 64'd2);
      if (vq.size() - nv0 == 2) begin
         check("t4.first", vq[nv0], 64'd7);
         check("t4.second", vq[nv0 + 1], 64'd8);
      end
      last_good = 64'd8;

      // reset mid-number
      nv0 = vq.size(); ne0 = eq.size();
      send_char("9", st);
      send_char("9", st);
      @(negedge clk);
      char_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t5.value_reset", value_out, 64'd0);
      check("t5.no_pulse", 64'(vq.size() - nv0 + eq.size() - ne0), 64'd0);
      last_good = '0;
      run_number("t5.after", "5\015", 1, 64'd5, 2'b00, 1'b0);

      for (int n = 0; n < 200; n++) begin
         body = "";
         if ($urandom_range(0, 3) == 0) body = " ";
         if ($urandom_range(0, 7) == 0) body = {body, "-"};
         case ($urandom_range(0, 3))
            0: body = {body, $sformatf("%0d", {$urandom, $urandom})};
            1: body = {body, boundary[$urandom_range(0, 5)]};
            2: for (int k = 0; k < int'($urandom_range(1, 22)); k++)
                  body = {body, $sformatf("%c", 8'h30 + 8'($urandom_range(0, 9)))};
            default: for (int k = 0; k < int'($urandom_range(1, 5)); k++)
                  body = {body, $sformatf("%c", 8'h30 + 8'($urandom_range(0, 9)))};
         endcase
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 3))
               0: bad_c = "a";
               1: bad_c = " ";
               2: bad_c = "/";
               default: bad_c = ":";
            endcase
            body[$urandom_range(0, body.len() - 1)] = bad_c[0];
         end
         term = ($urandom_range(0, 1) == 0) ? "\015" : "\012";
         model(body, kind, v, code);
         run_number($sformatf("rnd%0d", n), {body, term}, kind, v, code, 1'b1);
      end

      check("never_both", 64'(both_cnt), 64'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
